// File: rtl/run_length_monitor.sv
// Run-length monitor for a 2-bit up counter: extends the count with a wrap
// register and reports each run length through a valid/ready result register.
module run_length_monitor #(
    parameter int LEN_W   = 8,
    parameter int MIN_LEN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cond_in,
    input  logic [1:0]       cnt_in,
    output logic             len_valid,
    input  logic             len_ready,
    output logic [LEN_W-1:0] len_data,
    output logic             len_sat,
    output logic [CNT_W-1:0] run_total,
    output logic             ovf,
    output logic             seq_err,
    input  logic             err_clr
);

    localparam int HI_W = LEN_W - 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [HI_W-1:0]  hi_q, hi_d;
    logic [1:0]       shadow_q, shadow_d;
    logic             len_valid_q, len_valid_d;
    logic [LEN_W-1:0] len_data_q, len_data_d;
    logic             len_sat_q, len_sat_d;
    logic [CNT_W-1:0] run_total_q, run_total_d;
    logic             ovf_q, ovf_d;
    logic             seq_err_q, seq_err_d;

    logic             active;
    logic             run_end;
    logic             run_sat;
    logic [LEN_W-1:0] run_len;
    logic             qualify;
    logic             accept;
    logic             load;
    logic             drop;

    assign active = (cond_in != 2'd0);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        run_end = 1'b0;
        run_sat = 1'b0;
        run_len = '0;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = ST_RUN;
                    hi_d    = '0;
                end
            end
            ST_RUN: begin
                if (active) begin
                    // cnt_in==3 on an active edge means the counter wraps now
                    if (cnt_in == 2'd3) begin
                        if (&hi_q) state_d = ST_SAT;
                        else       hi_d    = hi_q + 1'b1;
                    end
                end else begin
                    run_end = 1'b1;
                    run_len = {hi_q, cnt_in};
                    hi_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SAT: begin
                if (!active) begin
                    run_end = 1'b1;
                    run_sat = 1'b1;
                    run_len = '1;
                    hi_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hi_d    = '0;
            end
        endcase
    end

    always_comb begin
        qualify     = run_end && (run_sat || (run_len >= LEN_W'(MIN_LEN)));
        accept      = len_valid_q && len_ready;
        load        = qualify && (!len_valid_q || len_ready);
        drop        = qualify && !load;
        len_valid_d = load || (len_valid_q && !accept);
        len_data_d  = load ? run_len : len_data_q;
        len_sat_d   = load ? run_sat : len_sat_q;
        run_total_d = run_total_q + CNT_W'(load);
        // set beats clear on the sticky flags
        ovf_d       = drop || (ovf_q && !err_clr);
        seq_err_d   = (cnt_in != shadow_q) || (seq_err_q && !err_clr);
        shadow_d    = active ? shadow_q + 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            shadow_q    <= '0;
            len_valid_q <= 1'b0;
            len_data_q  <= '0;
            len_sat_q   <= 1'b0;
            run_total_q <= '0;
            ovf_q       <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            shadow_q    <= shadow_d;
            len_valid_q <= len_valid_d;
            len_data_q  <= len_data_d;
            len_sat_q   <= len_sat_d;
            run_total_q <= run_total_d;
            ovf_q       <= ovf_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign len_valid = len_valid_q;
    assign len_data  = len_data_q;
    assign len_sat   = len_sat_q;
    assign run_total = run_total_q;
    assign ovf       = ovf_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_run_length_monitor.sv
// Directed bench for run_length_monitor; a bench-side 2-bit counter model
// drives cnt_in and can be overridden to inject sequence errors.
module tb_run_length_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cond_in;
    logic [1:0] cnt_in;
    logic       len_ready;
    logic       err_clr;

    logic       len_valid, len_sat, ovf, seq_err;
    logic [7:0] len_data, run_total;
    logic       m3_valid, m3_sat, m3_ovf, m3_seq_err;
    logic [7:0] m3_data, m3_total;

    logic [1:0] cnt_m;
    logic       force_en;
    logic [1:0] force_val;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    run_length_monitor #(.LEN_W(8), .MIN_LEN(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cond_in(cond_in), .cnt_in(cnt_in),
        .len_valid(len_valid), .len_ready(len_ready), .len_data(len_data),
        .len_sat(len_sat), .run_total(run_total), .ovf(ovf),
        .seq_err(seq_err), .err_clr(err_clr)
    );

    run_length_monitor #(.LEN_W(8), .MIN_LEN(3), .CNT_W(8)) u_dut_m3 (
        .clk(clk), .rst(rst), .cond_in(cond_in), .cnt_in(cnt_in),
        .len_valid(m3_valid), .len_ready(len_ready), .len_data(m3_data),
        .len_sat(m3_sat), .run_total(m3_total), .ovf(m3_ovf),
        .seq_err(m3_seq_err), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock edge with the given condition; outputs sampled 1ns after
    task automatic edge_(input logic [1:0] c);
        cond_in = c;
        cnt_in  = force_en ? force_val : cnt_m;
        @(posedge clk);
        cnt_m = (c != 2'd0) ? cnt_m + 2'd1 : 2'd0;
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) edge_(2'd1);
    endtask

    task automatic reset_pulse();
        rst   = 1'b0;
        cnt_m = 2'd0;
        #1;
        rst   = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        cond_in   = 2'd0;
        cnt_in    = 2'd0;
        len_ready = 1'b0;
        err_clr   = 1'b0;
        cnt_m     = 2'd0;
        force_en  = 1'b0;
        force_val = 2'd0;
        #12;
        chk("rst_valid", 32'(len_valid), 0);
        chk("rst_data", 32'(len_data), 0);
        chk("rst_sat", 32'(len_sat), 0);
        chk("rst_total", 32'(run_total), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_seq", 32'(seq_err), 0);
        rst = 1'b1;

        // basic 5-run
        len_ready = 1'b1;
        hold(5);
        chk("r5_pre_valid", 32'(len_valid), 0);
        edge_(2'd0);
        chk("r5_valid", 32'(len_valid), 1);
        chk("r5_data", 32'(len_data), 5);
        chk("r5_sat", 32'(len_sat), 0);
        chk("r5_total", 32'(run_total), 1);
        edge_(2'd0);
        chk("r5_drain", 32'(len_valid), 0);

        // mixed nonzero conditions stay one run
        edge_(2'd1); edge_(2'd2); edge_(2'd3); edge_(2'd2); edge_(2'd1);
        edge_(2'd0);
        chk("mix_data", 32'(len_data), 5);
        chk("mix_total", 32'(run_total), 2);
        edge_(2'd0);

        hold(4); edge_(2'd0);
        chk("r4_data", 32'(len_data), 4);
        chk("r4_total", 32'(run_total), 3);
        edge_(2'd0);
        hold(8); edge_(2'd0);
        chk("r8_data", 32'(len_data), 8);
        edge_(2'd0);
        hold(300); edge_(2'd0);
        chk("r300_data", 32'(len_data), 255);
        chk("r300_sat", 32'(len_sat), 1);
        chk("r300_total", 32'(run_total), 5);
        edge_(2'd0);
        hold(255); edge_(2'd0);
        chk("r255_data", 32'(len_data), 255);
        chk("r255_sat", 32'(len_sat), 0);
        chk("r255_total", 32'(run_total), 6);
        edge_(2'd0);
        chk("seq_clean", 32'(seq_err), 0);

        // async reset mid-run with hi=2
        hold(9);
        rst   = 1'b0;
        cnt_m = 2'd0;
        #1;
        chk("mrst_valid", 32'(len_valid), 0);
        chk("mrst_data", 32'(len_data), 0);
        chk("mrst_sat", 32'(len_sat), 0);
        chk("mrst_total", 32'(run_total), 0);
        rst = 1'b1;
        hold(2); edge_(2'd0);
        chk("mrst_run2", 32'(len_data), 2);
        chk("mrst_total1", 32'(run_total), 1);
        edge_(2'd0);

        // overflow with stalled consumer
        len_ready = 1'b0;
        hold(3); edge_(2'd0);
        chk("ov_r3_valid", 32'(len_valid), 1);
        chk("ov_r3_data", 32'(len_data), 3);
        edge_(2'd0);
        hold(6);
        chk("ov_stable", 32'(len_data), 3);
        edge_(2'd0);
        chk("ov_drop_data", 32'(len_data), 3);
        chk("ov_set", 32'(ovf), 1);
        chk("ov_drop_total", 32'(run_total), 2);
        edge_(2'd0);
        hold(6);
        len_ready = 1'b1;
        edge_(2'd0);
        chk("ov_swap_valid", 32'(len_valid), 1);
        chk("ov_swap_data", 32'(len_data), 6);
        chk("ov_sticky", 32'(ovf), 1);
        chk("ov_swap_total", 32'(run_total), 3);
        len_ready = 1'b0;
        err_clr   = 1'b1;
        edge_(2'd0);
        chk("ov_clr", 32'(ovf), 0);
        chk("ov_hold_valid", 32'(len_valid), 1);
        err_clr   = 1'b0;
        len_ready = 1'b1;
        edge_(2'd0);
        chk("ov_drain", 32'(len_valid), 0);

        // glitch filter on MIN_LEN=3 instance
        reset_pulse();
        hold(1); edge_(2'd0);
        chk("m3_r1", 32'(m3_valid), 0);
        hold(2); edge_(2'd0);
        chk("m3_r2", 32'(m3_valid), 0);
        hold(3); edge_(2'd0);
        chk("m3_r3_valid", 32'(m3_valid), 1);
        chk("m3_r3_data", 32'(m3_data), 3);
        chk("m3_total", 32'(m3_total), 1);
        chk("m3_ovf", 32'(m3_ovf), 0);
        chk("m1_total", 32'(run_total), 3);
        edge_(2'd0);

        // sequence error injection
        hold(1);
        chk("seq_pre", 32'(seq_err), 0);
        force_en  = 1'b1;
        force_val = 2'd2;
        edge_(2'd1);
        chk("seq_set", 32'(seq_err), 1);
        force_val = 2'd0;
        err_clr   = 1'b1;
        edge_(2'd1);
        chk("seq_set_wins", 32'(seq_err), 1);
        force_en = 1'b0;
        edge_(2'd1);
        chk("seq_clr", 32'(seq_err), 0);
        err_clr = 1'b0;
        edge_(2'd0);
        chk("seq_run_len", 32'(len_data), 4);
        chk("seq_no_ovf", 32'(ovf), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
